serial_mag_tx: RTL and testbench
================================

Name: serial_mag_tx

Overview:
- Transmitter and controller for the serial magnitude comparator.
- Accepts a pair of parallel WIDTH-bit words through a valid/ready handshake. Shifts them out MSB-first on two serial lines, one bit per clock.
- Holds the comparator cleared between words, then captures its gt/lt/eq verdict after the last bit and reports it as a one-cycle result pulse.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  word pair on a_word/b_word is valid.
- in_ready  output  1  block can accept a word pair this cycle.
- a_word  input  WIDTH  parallel operand A.
- b_word  input  WIDTH  parallel operand B.
- a_ser  output  1  serial A bit to comparator, MSB first.
- b_ser  output  1  serial B bit to comparator, MSB first.
- frame  output  1  high while a_ser/b_ser carry valid bits.
- cmp_clear  output  1  active-high clear for comparator flops; drives its reset_L through an inverter at the top level.
- gt_in  input  1  comparator AgtB.
- lt_in  input  1  comparator AltB.
- eq_in  input  1  comparator AeqB.
- result_valid  output  1  one-cycle pulse: result_* updated.
- result_gt  output  1  captured A>B.
- result_lt  output  1  captured A<B.
- result_eq  output  1  captured A==B.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, shift regs=0, counter=0.
  - a_ser=b_ser=0, frame=0, cmp_clear=1, in_ready=1.
  - result_valid=0, result_gt=result_lt=0, result_eq=1.
- States: IDLE, SHIFT, CAPTURE.
- All outputs are derived from registers only; no combinational path from any input to any output.
- IDLE:
  - in_ready=1, cmp_clear=1, frame=0, a_ser=b_ser=0.
  - On posedge with in_valid=1: load a_word/b_word into shift regs, counter=WIDTH-1, go to SHIFT.
  - With in_valid=0: stay in IDLE.
- SHIFT:
  - in_ready=0, cmp_clear=0, frame=1.
  - a_ser/b_ser = MSB of the respective shift reg.
  - Each posedge: shift both regs left by one, zero fill, counter decrements.
  - When counter==0 at the posedge, go to CAPTURE.
  - Exactly WIDTH SHIFT cycles; bit WIDTH-1 appears in the first SHIFT cycle and bit 0 in the last.
- CAPTURE:
  - in_ready=0, cmp_clear=0, frame=0, a_ser=b_ser=0.
  - The comparator flops hold the final verdict this cycle.
  - On posedge: register gt_in/lt_in/eq_in into result_*, set result_valid=1 for the next cycle only, go to IDLE.
- Latency and throughput:
  - Handshake edge to first serial bit: 1 cycle.
  - Handshake edge to result_valid: WIDTH+2 cycles.
  - Sustained throughput: one pair per WIDTH+2 cycles.
  - The IDLE cycle between words is mandatory; it is the comparator clear window.
- result_* hold their value until the next CAPTURE; result_valid is 0 except for its pulse.
- in_valid while not in IDLE: ignored. The word inputs are not sampled; the source must hold them until in_ready.
- Result pulse overlapping acceptance: result_valid=1 coincides with the IDLE cycle, so a new pair may be accepted in that same cycle. Both events are legal together.
- Reset during SHIFT/CAPTURE:
  - The transfer is abandoned and no result_valid is produced.
  - cmp_clear rises asynchronously with reset.
- Inconsistent comparator inputs (e.g. gt_in=lt_in=1): captured verbatim, no checking.
- Counter width: $clog2(WIDTH). Counter wrap cannot occur, because SHIFT exits at counter==0.

Decomposition:
- Package serial_mag_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} tx_state_t.
  - localparam default WIDTH.
- Sub-module piso_shift: parallel-load, left-shift register with load and shift_en.
  - Instantiated twice, once for A and once for B.
- FSM, counter and result capture live in serial_mag_tx.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset mid-cycle, release, hold in_valid=0.
  - Required: cmp_clear=1, in_ready=1, result_eq=1, frame=0 immediately and thereafter.
- WIDTH=8, a_word=8'hA5, b_word=8'hA4, with the real comparator attached:
  - Required serial stream a_ser=1,0,1,0,0,1,0,1 with frame=1 for exactly 8 cycles.
  - Required: result_valid pulses 10 cycles after the handshake edge, result_gt=1, result_lt=0, result_eq=0.
- Equal and less-than cases:
  - a=b=8'h3C -> result_eq=1.
  - a=8'h00, b=8'h80 -> result_lt=1, decided on the first bit.
- Back-to-back:
  - Stimulus: in_valid held high with 8'hFF/8'h01 then 8'h01/8'hFF.
  - Required: second acceptance in the same cycle as the first result_valid; results gt then lt; cmp_clear high for exactly 1 cycle between frames.
- Handshake ignore:
  - Stimulus: pulse in_valid with different data during SHIFT.
  - Required: serial stream and result unchanged, in_ready=0 throughout.
- Reset mid-SHIFT:
  - Stimulus: assert reset after 3 bits.
  - Required: immediate return to IDLE outputs, no result_valid. A following 8'h10/8'h0F transfer yields result_gt=1.

Source files
------------

// File: rtl/serial_mag_pkg.sv
// Shared types and defaults for the serial magnitude comparator transmitter.
package serial_mag_pkg;

  // Default word width; legal range is 2..32.
  localparam int DEFAULT_WIDTH = 8;

  // Transfer sequencing: wait for a pair, shift it out, then latch the verdict.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out register: parallel load, left shift with zero fill,
// MSB presented as the serial bit.
module piso_shift
  import serial_mag_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  // Load has priority over shift; zero fill empties the register by the end of a word.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values, regardless of process ordering.
    if (reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift_en) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/serial_mag_tx.sv
// Transmitter/controller for the serial magnitude comparator: accepts a word
// pair, shifts both MSB-first, holds the comparator cleared between words and
// reports the captured gt/lt/eq verdict as a one-cycle pulse.
module serial_mag_tx
  import serial_mag_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             a_ser,
  output logic             b_ser,
  output logic             frame,
  output logic             cmp_clear,
  input  logic             gt_in,
  input  logic             lt_in,
  input  logic             eq_in,
  output logic             result_valid,
  output logic             result_gt,
  output logic             result_lt,
  output logic             result_eq
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] cnt;
  logic          load, shift_en;
  logic          a_msb, b_msb;

  // Words are only sampled while idle; in_valid elsewhere is ignored.
  assign load     = (state == IDLE) && in_valid;
  assign shift_en = (state == SHIFT);

  piso_shift #(.WIDTH(WIDTH)) u_shift_a (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .din      (a_word),
    .msb      (a_msb)
  );

  piso_shift #(.WIDTH(WIDTH)) u_shift_b (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .din      (b_word),
    .msb      (b_msb)
  );

  // State register; reset returns to IDLE so cmp_clear rises with reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> SHIFT on handshake, SHIFT for WIDTH cycles, one CAPTURE cycle.
  always_comb begin
    // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from state and shift-register MSBs only; no input reaches an output.
  always_comb begin
    in_ready  = 1'b0;
    cmp_clear = 1'b0;
    frame     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready  = 1'b1;
        cmp_clear = 1'b1;
      end
      SHIFT:   frame = 1'b1;
      CAPTURE: ;
      default: begin
        in_ready  = 1'b1;
        cmp_clear = 1'b1;
      end
    endcase
    a_ser = a_msb & frame;
    b_ser = b_msb & frame;
  end

  // Bit counter: loaded with WIDTH-1, counts down through SHIFT and parks at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_LAST;
    end else if (shift_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Verdict capture: latch comparator flags verbatim in CAPTURE and pulse result_valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_valid <= 1'b0;
      result_gt    <= 1'b0;
      result_lt    <= 1'b0;
      result_eq    <= 1'b1;
    end else if (state == CAPTURE) begin
      result_valid <= 1'b1;
      result_gt    <= gt_in;
      result_lt    <= lt_in;
      result_eq    <= eq_in;
    end else begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_mag_tx.sv
// Self-checking bench for serial_mag_tx with a behavioural serial magnitude
// comparator attached to the serial lines.
module tb_serial_mag_tx;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         gt;
    logic         lt;
    logic         eq;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a_word = '0;
  logic [W-1:0] b_word = '0;
  logic         in_ready, a_ser, b_ser, frame, cmp_clear;
  logic         gt_in, lt_in, eq_in;
  logic         result_valid, result_gt, result_lt, result_eq;

  int n_checks = 0;
  int n_pass   = 0;

  serial_mag_tx #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_word       (a_word),
    .b_word       (b_word),
    .a_ser        (a_ser),
    .b_ser        (b_ser),
    .frame        (frame),
    .cmp_clear    (cmp_clear),
    .gt_in        (gt_in),
    .lt_in        (lt_in),
    .eq_in        (eq_in),
    .result_valid (result_valid),
    .result_gt    (result_gt),
    .result_lt    (result_lt),
    .result_eq    (result_eq)
  );

  always #5 clock = ~clock;

  // MSB-first comparator: the first differing bit decides, cleared asynchronously.
  logic cgt, clt;
  always_ff @(posedge clock or posedge cmp_clear) begin
    if (cmp_clear) begin
      cgt <= 1'b0;
      clt <= 1'b0;
    end else if (!cgt && !clt) begin
      cgt <= a_ser & ~b_ser;
      clt <= ~a_ser & b_ser;
    end
  end
  assign gt_in = cgt;
  assign lt_in = clt;
  assign eq_in = ~cgt & ~clt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready"},  in_ready,  1);
    check({tag, " cmp_clear"}, cmp_clear, 1);
    check({tag, " frame"},     frame,     0);
    check({tag, " a_ser"},     a_ser,     0);
    check({tag, " b_ser"},     b_ser,     0);
  endtask

  // One transfer starting at a negedge with the DUT idle. Ends at the negedge
  // of the result cycle. keep=1 holds in_valid with the next pair presented;
  // glitch=1 pulses in_valid with corrupted data mid-shift.
  task automatic xfer(input vec_t v, input bit keep, input logic [W-1:0] na,
                      input logic [W-1:0] nb, input bit glitch);
    in_valid = 1'b1;
    a_word   = v.a;
    b_word   = v.b;
    check("accept in_ready", in_ready, 1);
    @(posedge clock);
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      @(negedge clock);
      if (cyc == 1) begin
        if (keep) begin
          a_word = na;
          b_word = nb;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (glitch && cyc == 3) begin
        in_valid = 1'b1;
        a_word   = ~v.a;
        b_word   = ~v.b;
      end
      if (glitch && cyc == 5) in_valid = 1'b0;
      check("busy in_ready", in_ready, 0);
      check("busy cmp_clear", cmp_clear, 0);
      check("busy result_valid", result_valid, 0);
      if (cyc <= W) begin
        check("shift frame", frame, 1);
        check("shift a_ser", a_ser, v.a[W-cyc]);
        check("shift b_ser", b_ser, v.b[W-cyc]);
      end else begin
        check("capture frame", frame, 0);
        check("capture a_ser", a_ser, 0);
        check("capture b_ser", b_ser, 0);
      end
    end
    @(negedge clock);
    check("result_valid pulse", result_valid, 1);
    check("result_gt", result_gt, v.gt);
    check("result_lt", result_lt, v.lt);
    check("result_eq", result_eq, v.eq);
    check("result cycle in_ready", in_ready, 1);
    check("result cycle cmp_clear", cmp_clear, 1);
    check("result cycle frame", frame, 0);
  endtask

  // Result pulse must drop and the verdict must hold afterwards.
  task automatic after_result(input vec_t v);
    @(negedge clock);
    check("pulse ends", result_valid, 0);
    check("hold gt", result_gt, v.gt);
    check("hold lt", result_lt, v.lt);
    check("hold eq", result_eq, v.eq);
    check_idle("post");
  endtask

  vec_t vecs[7];
  vec_t v_rst;

  initial begin
    vecs[0] = '{a: 8'hA5, b: 8'hA4, gt: 1'b1, lt: 1'b0, eq: 1'b0};
    vecs[1] = '{a: 8'h3C, b: 8'h3C, gt: 1'b0, lt: 1'b0, eq: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'h80, gt: 1'b0, lt: 1'b1, eq: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, gt: 1'b0, lt: 1'b0, eq: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'h80, gt: 1'b0, lt: 1'b1, eq: 1'b0};
    vecs[5] = '{a: 8'h01, b: 8'h00, gt: 1'b1, lt: 1'b0, eq: 1'b0};
    vecs[6] = '{a: 8'hFF, b: 8'h01, gt: 1'b1, lt: 1'b0, eq: 1'b0};
    v_rst   = '{a: 8'h10, b: 8'h0F, gt: 1'b1, lt: 1'b0, eq: 1'b0};

    // Reset asserted mid-cycle; outputs must take reset values immediately.
    #3 reset = 1'b1;
    #1;
    check_idle("reset");
    check("reset result_valid", result_valid, 0);
    check("reset result_gt", result_gt, 0);
    check("reset result_lt", result_lt, 0);
    check("reset result_eq", result_eq, 1);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_idle("idle");
      check("idle result_valid", result_valid, 0);
      check("idle result_eq", result_eq, 1);
    end

    // Table-driven single transfers.
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i], 1'b0, '0, '0, 1'b0);
      after_result(vecs[i]);
    end

    // Back-to-back: second pair accepted in the result cycle of the first.
    xfer(vecs[6], 1'b1, 8'h01, 8'hFF, 1'b0);
    xfer('{a: 8'h01, b: 8'hFF, gt: 1'b0, lt: 1'b1, eq: 1'b0}, 1'b0, '0, '0, 1'b0);
    after_result('{a: 8'h01, b: 8'hFF, gt: 1'b0, lt: 1'b1, eq: 1'b0});

    // in_valid pulsed with different data during SHIFT is ignored.
    xfer(vecs[0], 1'b0, '0, '0, 1'b1);
    after_result(vecs[0]);

    // Reset after three bits abandons the transfer.
    in_valid = 1'b1;
    a_word   = 8'h5A;
    b_word   = 8'h33;
    @(posedge clock);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clock);
      in_valid = 1'b0;
      check("pre-reset a_ser", a_ser, a_word[W-cyc]);
    end
    #2 reset = 1'b1;
    #1;
    check_idle("mid reset");
    check("mid reset result_valid", result_valid, 0);
    check("mid reset result_eq", result_eq, 1);
    check("mid reset result_gt", result_gt, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int cyc = 0; cyc < W + 4; cyc++) begin
      @(negedge clock);
      check("no result after reset", result_valid, 0);
      check("no frame after reset", frame, 0);
    end
    xfer(v_rst, 1'b0, '0, '0, 1'b0);
    after_result(v_rst);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety bound in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
